fb_write_scheduler: RTL and testbench

Owns the single framebuffer write port and shares it between the framebuffer clear engine and `NUM_REQ` sprite renderers. On every `frame_start` it sweeps the whole framebuffer with `CLEAR_COLOR`, one pixel per clock, while all renderers are stalled. Outside a clear it grants renderer pixel writes round-robin through a valid/ready handshake. It sits between the sprite renderers and the framebuffer write port, replacing the per-renderer dedicated write ports.

---
 rtl/fb_write_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//
// Owns the single framebuffer write port. Each frame_start sweeps the whole
// framebuffer with CLEAR_COLOR, one pixel per clock, while every renderer is
// stalled. Outside a sweep the port is shared round-robin between NUM_REQ
// sprite renderers through a valid/ready handshake.
//
// Ports
//   clock, reset   single clock; asynchronous active-high reset
//   frame_start    one-cycle pulse, (re)starts a clear sweep
//   req_valid      per-renderer write request
//   req_addr       packed 19-bit pixel addresses, renderer i at [19i+18:19i]
//   req_data       packed 4-bit pixel values, renderer i at [4i+3:4i]
//   req_ready      combinational grant, one-hot or zero
//   fb_wr_addr     registered framebuffer write address
//   fb_wr_data     registered framebuffer write data
//   fb_wr_en       registered framebuffer write strobe
//   clear_busy     high while the clear sweep runs
//   clear_done     one-cycle pulse after a sweep completes
//   drop_count     saturating count of out-of-range requests
module fb_write_scheduler #(
    parameter int         NUM_REQ     = 2,
    parameter int         FB_PIXELS   = 480000,
    parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*19-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [18:0]           fb_wr_addr,
    output logic [3:0]            fb_wr_data,
    output logic                  fb_wr_en,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [15:0]           drop_count
);

    localparam int          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          POS_W     = PTR_W + 1;
    localparam logic [19:0] PIX_LIMIT = 20'(FB_PIXELS);
    localparam logic [18:0] LAST_PIX  = 19'(FB_PIXELS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [18:0]      clear_cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             xfer;
    logic             last_clear;
    logic             in_range;
    logic [18:0]      gnt_addr;
    logic [3:0]       gnt_data;
    logic [18:0]      addr_arr [NUM_REQ];
    logic [3:0]       data_arr [NUM_REQ];

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Returns {found, index} of the first valid requester searching upward
    // from ptr+1 (mod NUM_REQ). Iterating from the farthest candidate down
    // lets the nearest one overwrite the result.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [PTR_W-1:0]   ptr);
        logic [POS_W-1:0] pos;
        logic [PTR_W:0]   pick;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = {1'b0, ptr} + POS_W'(k);
            if (pos >= POS_W'(NUM_REQ)) begin
                pos = pos - POS_W'(NUM_REQ);
            end
            if (valid[pos[PTR_W-1:0]]) begin
                pick = {1'b1, pos[PTR_W-1:0]};
            end
        end
        return pick;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*19 +: 19];
            assign data_arr[gi] = req_data[gi*4 +: 4];
        end
    endgenerate

    assign gnt_addr   = addr_arr[gnt_idx];
    assign gnt_data   = data_arr[gnt_idx];
    assign in_range   = ({1'b0, gnt_addr} < PIX_LIMIT);
    assign last_clear = (clear_cnt == LAST_PIX);
    assign clear_busy = (state == ST_CLEAR);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a frame_start always wins over sweep completion
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (!frame_start && last_clear) state_nxt = ST_RUN;
            ST_RUN:   if (frame_start)                state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Output logic: grant only in RUN, and only to a requester that is valid,
    // so any asserted ready bit is a transfer this cycle.
    always_comb begin
        {gnt_found, gnt_idx} = rr_pick(req_valid, rr_ptr);
        req_ready = '0;
        xfer      = 1'b0;
        if (state == ST_RUN && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            xfer               = 1'b1;
        end
    end

    // Write port register stage and sweep/arbitration bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_cnt  <= '0;
            rr_ptr     <= PTR_W'(NUM_REQ - 1);
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            fb_wr_en   <= 1'b0;
            clear_done <= 1'b0;
            drop_count <= '0;
        end else begin
            clear_done <= (state == ST_CLEAR) && last_clear && !frame_start;
            if (state == ST_CLEAR) begin
                // The current pixel is still written on a restart; the
                // following write begins again at address 0.
                fb_wr_en   <= 1'b1;
                fb_wr_addr <= clear_cnt;
                fb_wr_data <= CLEAR_COLOR;
                if (frame_start || last_clear) begin
                    clear_cnt <= '0;
                end else begin
                    clear_cnt <= clear_cnt + 19'd1;
                end
            end else begin
                fb_wr_en <= xfer && in_range;
                if (xfer) begin
                    rr_ptr <= gnt_idx;
                end
                if (xfer && in_range) begin
                    fb_wr_addr <= gnt_addr;
                    fb_wr_data <= gnt_data;
                end
                if (xfer && !in_range) begin
                    drop_count <= sat_inc16(drop_count);
                end
                if (frame_start) begin
                    clear_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
module tb_fb_write_scheduler;

    localparam int NUM_REQ   = 2;
    localparam int FB_PIXELS = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [37:0] req_addr = '0;
    logic [7:0]  req_data = '0;
    logic [1:0]  req_ready;
    logic [18:0] fb_wr_addr;
    logic [3:0]  fb_wr_data;
    logic        fb_wr_en;
    logic        clear_busy;
    logic        clear_done;
    logic [15:0] drop_count;

    fb_write_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .FB_PIXELS  (FB_PIXELS),
        .CLEAR_COLOR(4'h0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_start(frame_start),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_wr_en   (fb_wr_en),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  data;
    } wr_t;

    int  nchk = 0;
    int  nfail = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    // Reference model: "clearing" flag plus next sweep pixel, last granted
    // requester, and expected drop total.
    bit m_clear;
    int m_cnt;
    int m_last;
    int m_drop;
    bit m_done;
    bit m_en;
    int last_grant;
    int n_done;

    // Renderer-side pending requests (held until granted)
    bit pv[NUM_REQ];
    int pa[NUM_REQ];
    int pd[NUM_REQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (m_last + k) % NUM_REQ;
            if (((v >> i) & 2'b01) != 2'b00) return i;
        end
        return -1;
    endfunction

    task automatic model_init();
        m_clear = 1'b1;
        m_cnt   = 0;
        m_last  = NUM_REQ - 1;
        m_drop  = 0;
        for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        pv[i] = 1'b1;
        pa[i] = a;
        pd[i] = d;
    endtask

    task automatic drive_reqs();
        req_valid = {pv[1], pv[0]};
        req_addr  = {19'(pa[1]), 19'(pa[0])};
        req_data  = {4'(pd[1]), 4'(pd[0])};
    endtask

    // One clock of stimulus: drive inputs, predict, let the edge happen,
    // then compare the per-cycle outputs. Writes go to the scoreboard.
    task automatic step(input bit fs);
        int         g;
        logic [1:0] exp_rdy;
        wr_t        w;
        frame_start = fs;
        drive_reqs();
        #1;
        exp_rdy    = 2'b00;
        m_done     = 1'b0;
        m_en       = 1'b0;
        last_grant = -1;
        if (m_clear) begin
            w.addr = 19'(m_cnt);
            w.data = 4'h0;
            exp_q.push_back(w);
            m_en = 1'b1;
            if (fs) begin
                m_cnt = 0;
            end else if (m_cnt == FB_PIXELS - 1) begin
                m_clear = 1'b0;
                m_cnt   = 0;
                m_done  = 1'b1;
            end else begin
                m_cnt++;
            end
        end else begin
            g = pick(req_valid);
            if (g >= 0) begin
                exp_rdy    = 2'(1 << g);
                m_last     = g;
                last_grant = g;
                pv[g]      = 1'b0;
                if (pa[g] < FB_PIXELS) begin
                    w.addr = 19'(pa[g]);
                    w.data = 4'(pd[g]);
                    exp_q.push_back(w);
                    m_en = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (fs) begin
                m_clear = 1'b1;
                m_cnt   = 0;
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        check("fb_wr_en", 32'(fb_wr_en), 32'(m_en));
        check("clear_busy", 32'(clear_busy), 32'(m_clear));
        check("clear_done", 32'(clear_done), 32'(m_done));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        if (clear_done === 1'b1) n_done++;
    endtask

    // Scoreboard monitor: every presented write must match the oldest
    // expected write.
    always @(negedge clock) begin
        if (reset === 1'b0 && fb_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL fb_write_unexpected: got addr %0d, expected no write", fb_wr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("fb_wr_addr", 32'(fb_wr_addr), 32'(mon_e.addr));
                check("fb_wr_data", 32'(fb_wr_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        model_init();
        n_done = 0;

        // Reset values, with requests pending to prove ready stays low
        reset     = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_fb_wr_addr", 32'(fb_wr_addr), 32'd0);
        check("rst_fb_wr_data", 32'(fb_wr_data), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd1);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Power-up sweep
        repeat (18) step(1'b0);
        check("sweep_done_pulses", 32'(n_done), 32'd1);

        // Round-robin with both requesters valid
        for (int k = 0; k < 6; k++) begin
            if (!pv[0]) set_req(0, k, k + 1);
            if (!pv[1]) set_req(1, k + 8, k + 9);
            step(1'b0);
            check("rr_grant", 32'(last_grant), 32'(k % 2));
        end
        repeat (2) step(1'b0);

        // Requester 1 alone at full rate
        for (int k = 0; k < 10; k++) begin
            set_req(1, 4 + k, k);
            step(1'b0);
            check("stream_grant", 32'(last_grant), 32'd1);
        end
        step(1'b0);

        // Out-of-range request is accepted and dropped
        d0 = int'(drop_count);
        set_req(0, FB_PIXELS, 5);
        step(1'b0);
        check("oor_drop_inc", 32'(drop_count), 32'(d0 + 1));

        // frame_start in the middle of a sweep
        step(1'b1);
        n_done = 0;
        for (int k = 0; k < 20 && m_cnt != 9; k++) step(1'b0);
        step(1'b1);
        repeat (20) step(1'b0);
        check("restart_done_pulses", 32'(n_done), 32'd1);

        // frame_start on the final sweep write
        step(1'b1);
        n_done = 0;
        for (int k = 0; k < 20 && m_cnt != FB_PIXELS - 1; k++) step(1'b0);
        step(1'b1);
        repeat (18) step(1'b0);
        check("last_restart_done_pulses", 32'(n_done), 32'd1);

        // Randomised traffic with occasional frame_start
        repeat (400) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 17)), int'($urandom_range(0, 15)));
            end
            step($urandom_range(0, 59) == 0);
        end

        // Drain to RUN with nothing pending, then stream and reset mid-cycle
        for (int k = 0; k < 40 && (m_clear || pv[0] || pv[1]); k++) step(1'b0);
        for (int k = 0; k < 3; k++) begin
            if (!pv[0]) set_req(0, 2 + k, 7);
            if (!pv[1]) set_req(1, 10 + k, 3);
            step(1'b0);
        end
        if (!pv[0]) set_req(0, 1, 9);
        if (!pv[1]) set_req(1, 11, 9);
        drive_reqs();
        @(posedge clock);
        #1;
        check("pre_reset_fb_wr_en", 32'(fb_wr_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
        check("async_rst_clear_busy", 32'(clear_busy), 32'd1);
        check("async_rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        model_init();
        drive_reqs();
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        n_done = 0;
        repeat (18) step(1'b0);
        check("post_reset_done_pulses", 32'(n_done), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
